video_timing_sequencer: RTL and testbench
=========================================

# video_timing_sequencer

Sequences the composite-video timing for the testcard output stage: generates horizontal and vertical counters, the composite sync waveform (line sync plus broad vertical pulses), and a pixel-request handshake to a pattern source. Sits between the 12 MHz system clock domain and the two-pin sync/white DAC, replacing ad-hoc timing inside pattern generators. Format is 312-line progressive, 64 µs lines, 50 Hz frames.

## Interface
- H_TOTAL, 768: clocks per line (64 µs at 12 MHz)
- H_SYNC, 56: line sync low width (4.7 µs)
- H_BACK, 68: back porch clocks
- H_ACTIVE, 624: active pixel clocks per line
- V_TOTAL, 312: lines per frame
- V_SYNC_LINES, 3: lines carrying broad pulses (lines 0..2)
- V_ACT_START, 23: first active line
- V_ACT_LINES, 287: active lines (23..309)
- BROAD_LOW, 328: broad pulse low width per half-line (half-line = H_TOTAL/2)

- clk  in  1  system clock, 12 MHz
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  run request; sampled each cycle
- i_pix  in  1  pixel value from pattern source, valid one cycle after o_pix_req
- o_pix_req  out  1  pixel request, high for active region
- o_x  out  10  active pixel index 0..H_ACTIVE-1, valid with o_pix_req
- o_y  out  9  active line index 0..V_ACT_LINES-1, valid with o_pix_req
- o_frame_start  out  1  one-cycle strobe at h=0, v=0
- o_sync  out  1  composite sync, 0 = sync tip
- o_white  out  1  video level, 1 = white

## Operation
- Counters h (0..H_TOTAL-1), v (0..V_TOTAL-1); h wraps to 0 and v increments at h=H_TOTAL-1; v wraps to 0 at V_TOTAL-1, h=H_TOTAL-1.
- Line type FSM, updated at each line wrap: VSYNC (v 0..2) -> BLANK (v 3..22) -> ACTIVE (v 23..309) -> BLANK (v 310..311) -> VSYNC.
- VSYNC lines: sync raw low for h in [0,BROAD_LOW) and [384,384+BROAD_LOW), high otherwise.
- BLANK/ACTIVE lines: sync raw low for h in [0,H_SYNC).
- Active region: line ACTIVE and h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) = [124,748).
- Run control FSM: IDLE -> RUN when i_en=1 (h,v start at 0, first cycle is frame start). RUN -> DRAIN when i_en=0; DRAIN completes the current frame then -> IDLE at wrap to v=0,h=0, unless i_en=1 again, which stays RUN with no gap.
- IDLE: counters held at 0, o_sync=1, o_white=0, o_pix_req=0, no strobe.
- o_white = i_pix AND active region (delayed); forced 0 outside active region regardless of i_pix.
- Counter widths: h 10 bit, v 9 bit; no overflow states reachable; values outside range never appear on ports.

## Timing
- Reset values: o_sync=1, o_white=0, o_pix_req=0, o_x=0, o_y=0, o_frame_start=0; FSM IDLE.
- Cycle t: registered o_pix_req/o_x/o_y/o_frame_start for counter position t.
- t+1: source drives i_pix (registered source).
- t+2: o_sync and o_white registered; o_sync pipelined two stages so both pins align with position t. o_frame_start precedes its sync edge by 2 cycles.
- o_x increments every cycle while o_pix_req=1; o_x=0 at h=124, 623 at h=747.
- Reset mid-frame: all outputs return to reset values asynchronously; pipeline flushed; restart at v=0 on next i_en.
- i_en deasserted and reasserted within the same frame: no disturbance to timing.

## Structure
- Package video_timing_pkg: default timing constants above, line type enum (VSYNC, BLANK, ACTIVE), run state enum (IDLE, RUN, DRAIN).
- One sub-module: video_hcounter (wrapping counter with terminal-count strobe), used for h; v counter enabled by its strobe.
- Output 2-stage alignment pipeline kept in top level.

## Test plan
- Reset, i_en=1: first o_frame_start 1 cycle after enable; o_sync falls 2 cycles later; line period 768 clocks, frame 239616 clocks.
- Line 30: o_sync low exactly 56 clocks; o_pix_req high exactly 624 clocks starting h=124, o_x 0..623, o_y=7.
- Lines 0..2: two low pulses per line of 328 clocks, starting h=0 and h=384; no o_pix_req.
- i_pix=1 constant: o_white high only for 624 clocks on lines 23..309, aligned with sync (rises 124 clocks after line sync falls).
- i_en=0 at v=100: frame completes to v=311, then o_sync stays 1, no further strobes; reassert -> restart at v=0.
- Assert i_rst_n=0 at v=50,h=400: outputs at reset values within same cycle; release with i_en=1 -> clean restart at frame start.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing constants and state types for the composite-video timing sequencer.
// Default format: 312-line progressive, 64 us lines at 12 MHz.
package video_timing_pkg;

  localparam int unsigned H_TOTAL      = 768;
  localparam int unsigned H_SYNC       = 56;
  localparam int unsigned H_BACK       = 68;
  localparam int unsigned H_ACTIVE     = 624;
  localparam int unsigned V_TOTAL      = 312;
  localparam int unsigned V_SYNC_LINES = 3;
  localparam int unsigned V_ACT_START  = 23;
  localparam int unsigned V_ACT_LINES  = 287;
  localparam int unsigned BROAD_LOW    = 328;

  typedef enum logic [1:0] {
    VSYNC  = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } line_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } run_state_e;

endpackage

// File: rtl/video_hcounter.sv
// Wrapping counter 0..TOTAL-1 with a terminal-count strobe and a look-ahead of the
// next count, so callers can register outputs aligned with the counter itself.
module video_hcounter
  import video_timing_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned TOTAL = H_TOTAL
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_s;

  always_comb begin
    tc_s    = i_en && (count_q == LAST);
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (tc_s) begin
      count_d = '0;
    end else if (i_en) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_next  = count_d;
  assign o_tc    = tc_s;

endmodule

// File: rtl/video_timing_sequencer.sv
// Composite-video timing sequencer: h/v counters, line-type and run-control FSMs,
// pixel-request handshake and a two-stage pipeline aligning sync and white pins.
module video_timing_sequencer
  import video_timing_pkg::*;
#(
  parameter int unsigned P_H_TOTAL      = H_TOTAL,
  parameter int unsigned P_H_SYNC       = H_SYNC,
  parameter int unsigned P_H_BACK       = H_BACK,
  parameter int unsigned P_H_ACTIVE     = H_ACTIVE,
  parameter int unsigned P_V_TOTAL      = V_TOTAL,
  parameter int unsigned P_V_SYNC_LINES = V_SYNC_LINES,
  parameter int unsigned P_V_ACT_START  = V_ACT_START,
  parameter int unsigned P_V_ACT_LINES  = V_ACT_LINES,
  parameter int unsigned P_BROAD_LOW    = BROAD_LOW
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_pix,
  output logic       o_pix_req,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_frame_start,
  output logic       o_sync,
  output logic       o_white
);

  localparam logic [9:0] H_SYNC_END = 10'(P_H_SYNC);
  localparam logic [9:0] H_ACT_BEG  = 10'(P_H_SYNC + P_H_BACK);
  localparam logic [9:0] H_ACT_END  = 10'(P_H_SYNC + P_H_BACK + P_H_ACTIVE);
  localparam logic [9:0] H_HALF     = 10'(P_H_TOTAL / 2);
  localparam logic [9:0] BROAD1_END = 10'(P_BROAD_LOW);
  localparam logic [9:0] BROAD2_END = 10'(P_H_TOTAL / 2 + P_BROAD_LOW);
  localparam logic [8:0] V_LAST     = 9'(P_V_TOTAL - 1);
  localparam logic [8:0] V_SYNC_END = 9'(P_V_SYNC_LINES);
  localparam logic [8:0] V_ACT_BEG  = 9'(P_V_ACT_START);
  localparam logic [8:0] V_ACT_END  = 9'(P_V_ACT_START + P_V_ACT_LINES);

  run_state_e state_q, state_d;
  line_type_e line_q, line_d;
  logic [8:0] v_q, v_d;
  logic [9:0] h_s, h_next_s;
  logic       h_tc_s, cnt_en_s, cnt_clr_s, frame_end_s;
  logic       run_next_s, act_next_s, sync_raw_s;
  logic       pix_req_q, pix_req_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       frame_start_q, frame_start_d;
  logic       sync_dly_q, sync_dly_d;
  logic       sync_q, sync_d;
  logic       act_dly_q, act_dly_d;
  logic       white_q, white_d;

  assign cnt_en_s    = (state_q != IDLE);
  assign cnt_clr_s   = (state_q == IDLE);
  assign frame_end_s = h_tc_s && (v_q == V_LAST);

  video_hcounter #(
    .WIDTH (10),
    .TOTAL (P_H_TOTAL)
  ) u_hcounter (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_clr   (cnt_clr_s),
    .i_en    (cnt_en_s),
    .o_count (h_s),
    .o_next  (h_next_s),
    .o_tc    (h_tc_s)
  );

  // Run control: DRAIN finishes the frame in progress unless i_en returns first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_en) state_d = RUN;
        else      state_d = IDLE;
      end
      RUN, DRAIN: begin
        if (i_en)             state_d = RUN;
        else if (frame_end_s) state_d = IDLE;
        else                  state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Vertical counter and line type both advance only on the horizontal wrap.
  always_comb begin
    v_d    = v_q;
    line_d = line_q;
    if (state_q == IDLE) begin
      v_d    = 9'd0;
      line_d = VSYNC;
    end else if (h_tc_s) begin
      v_d = (v_q == V_LAST) ? 9'd0 : v_q + 9'd1;
      case (line_q)
        VSYNC: begin
          if (v_d == V_SYNC_END) line_d = BLANK;
          else                   line_d = VSYNC;
        end
        BLANK: begin
          if (v_d == V_ACT_BEG)  line_d = ACTIVE;
          else if (v_d == 9'd0)  line_d = VSYNC;
          else                   line_d = BLANK;
        end
        ACTIVE: begin
          if (v_d == V_ACT_END)  line_d = BLANK;
          else                   line_d = ACTIVE;
        end
        default: line_d = VSYNC;
      endcase
    end else begin
      v_d    = v_q;
      line_d = line_q;
    end
  end

  // Request-side outputs use the next position so they land aligned with the counters.
  always_comb begin
    run_next_s    = (state_d != IDLE);
    act_next_s    = run_next_s && (line_d == ACTIVE) &&
                    (h_next_s >= H_ACT_BEG) && (h_next_s < H_ACT_END);
    pix_req_d     = act_next_s;
    x_d           = act_next_s ? (h_next_s - H_ACT_BEG) : 10'd0;
    y_d           = act_next_s ? (v_d - V_ACT_BEG) : 9'd0;
    frame_start_d = run_next_s && (h_next_s == 10'd0) && (v_d == 9'd0);
  end

  // Raw composite sync for the current position; broad pulses on VSYNC lines.
  always_comb begin
    sync_raw_s = 1'b1;
    if (state_q == IDLE) begin
      sync_raw_s = 1'b1;
    end else if (line_q == VSYNC) begin
      sync_raw_s = !((h_s < BROAD1_END) || ((h_s >= H_HALF) && (h_s < BROAD2_END)));
    end else begin
      sync_raw_s = !(h_s < H_SYNC_END);
    end
  end

  // Two-stage alignment: i_pix arrives one cycle after the request it answers.
  always_comb begin
    sync_dly_d = sync_raw_s;
    sync_d     = sync_dly_q;
    act_dly_d  = pix_req_q;
    white_d    = i_pix & act_dly_q;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      line_q        <= VSYNC;
      v_q           <= 9'd0;
      pix_req_q     <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      frame_start_q <= 1'b0;
      sync_dly_q    <= 1'b1;
      sync_q        <= 1'b1;
      act_dly_q     <= 1'b0;
      white_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      line_q        <= line_d;
      v_q           <= v_d;
      pix_req_q     <= pix_req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      sync_dly_q    <= sync_dly_d;
      sync_q        <= sync_d;
      act_dly_q     <= act_dly_d;
      white_q       <= white_d;
    end
  end

  assign o_pix_req     = pix_req_q;
  assign o_x           = x_q;
  assign o_y           = y_q;
  assign o_frame_start = frame_start_q;
  assign o_sync        = sync_q;
  assign o_white       = white_q;

endmodule

// File: tb/tb_video_timing_sequencer.sv
// Self-checking bench for video_timing_sequencer with a shortened frame (16 lines) and
// full-width lines; expectations come from a position-based model of the timing rules.
module tb_video_timing_sequencer;

  localparam int HT    = 768;
  localparam int HS    = 56;
  localparam int HB    = 68;
  localparam int HA    = 624;
  localparam int VT    = 16;
  localparam int VSL   = 3;
  localparam int VAS   = 6;
  localparam int VAL   = 8;
  localparam int BL    = 328;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       i_rst_n;
  logic       i_en;
  logic       i_pix;
  logic       o_pix_req;
  logic [9:0] o_x;
  logic [8:0] o_y;
  logic       o_frame_start;
  logic       o_sync;
  logic       o_white;

  always #5 clk = ~clk;

  video_timing_sequencer #(
    .P_H_TOTAL      (HT),
    .P_H_SYNC       (HS),
    .P_H_BACK       (HB),
    .P_H_ACTIVE     (HA),
    .P_V_TOTAL      (VT),
    .P_V_SYNC_LINES (VSL),
    .P_V_ACT_START  (VAS),
    .P_V_ACT_LINES  (VAL),
    .P_BROAD_LOW    (BL)
  ) dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_pix         (i_pix),
    .o_pix_req     (o_pix_req),
    .o_x           (o_x),
    .o_y           (o_y),
    .o_frame_start (o_frame_start),
    .o_sync        (o_sync),
    .o_white       (o_white)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: running flag, absolute position since start, and two pipeline taps.
  bit         m_run;
  int         m_pos;
  bit         m_sync_d1;
  bit         m_act_d1;
  logic       e_sync, e_white, e_req, e_fs;
  logic [9:0] e_x;
  logic [8:0] e_y;

  bit pix_const;
  bit meas_on;
  int cnt_fs, cnt_req, cnt_slow, cnt_white, max_x, max_y;

  function automatic bit f_active(int h, int v);
    return (v >= VAS) && (v < VAS + VAL) && (h >= HS + HB) && (h < HS + HB + HA);
  endfunction

  function automatic bit f_sync(int h, int v);
    if (v < VSL) return !((h < BL) || ((h >= HT / 2) && (h < HT / 2 + BL)));
    return !(h < HS);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_sync_d1 = 1'b1; m_act_d1 = 1'b0;
    e_sync = 1'b1; e_white = 1'b0; e_req = 1'b0; e_fs = 1'b0; e_x = 10'd0; e_y = 9'd0;
  endtask

  task automatic model_edge(bit en, bit pix);
    int h, v;
    bit raw, act;
    h   = m_pos % HT;
    v   = (m_pos / HT) % VT;
    raw = m_run ? f_sync(h, v) : 1'b1;
    act = m_run && f_active(h, v);
    e_sync    = m_sync_d1;
    m_sync_d1 = raw;
    e_white   = m_act_d1 & pix;
    m_act_d1  = act;
    if (!m_run) begin
      if (en) begin m_run = 1'b1; m_pos = 0; end
    end else if ((m_pos % FRAME == FRAME - 1) && !en) begin
      m_run = 1'b0; m_pos = 0;
    end else begin
      m_pos++;
    end
    h     = m_pos % HT;
    v     = (m_pos / HT) % VT;
    e_fs  = m_run && (m_pos % FRAME == 0);
    e_req = m_run && f_active(h, v);
    e_x   = e_req ? 10'(h - (HS + HB)) : 10'd0;
    e_y   = e_req ? 9'(v - VAS) : 9'd0;
  endtask

  task automatic step(bit en);
    i_en  = en;
    i_pix = pix_const ? 1'b1 : 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(i_en, i_pix);
    @(negedge clk);
    chk("frame_start", o_frame_start, e_fs);
    chk("pix_req", o_pix_req, e_req);
    chk("x", o_x, e_x);
    chk("y", o_y, e_y);
    chk("sync", o_sync, e_sync);
    chk("white", o_white, e_white);
    if (meas_on) begin
      if (o_frame_start) cnt_fs++;
      if (o_pix_req) cnt_req++;
      if (!o_sync) cnt_slow++;
      if (o_white) cnt_white++;
      if (o_pix_req && int'(o_x) > max_x) max_x = int'(o_x);
      if (o_pix_req && int'(o_y) > max_y) max_y = int'(o_y);
    end
  endtask

  task automatic meas_clear();
    cnt_fs = 0; cnt_req = 0; cnt_slow = 0; cnt_white = 0; max_x = 0; max_y = 0;
  endtask

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_pix = 1'b0; pix_const = 1'b0; meas_on = 1'b0;
    model_reset();
    meas_clear();
    repeat (3) @(negedge clk);
    chk("rst_sync", o_sync, 1'b1);
    chk("rst_white", o_white, 1'b0);
    chk("rst_pix_req", o_pix_req, 1'b0);
    chk("rst_x", o_x, 10'd0);
    chk("rst_y", o_y, 9'd0);
    chk("rst_frame_start", o_frame_start, 1'b0);
    i_rst_n = 1'b1;
    repeat (4) step(1'b0);

    // Enable: strobe on the first edge, sync tip two cycles after the strobe.
    step(1'b1);
    chk("first_strobe", o_frame_start, 1'b1);
    step(1'b1);
    chk("sync_before_fall", o_sync, 1'b1);
    step(1'b1);
    chk("sync_fall_2cyc", o_sync, 1'b0);
    while (m_pos != FRAME - 1) step(1'b1);

    // Second frame with a constant white source, measured over exactly one frame.
    pix_const = 1'b1;
    meas_on   = 1'b1;
    repeat (FRAME) step(1'b1);
    meas_on   = 1'b0;
    pix_const = 1'b0;
    chk("frame_strobes", cnt_fs, 1);
    chk("frame_pix_req", cnt_req, HA * VAL);
    chk("frame_sync_low", cnt_slow, VSL * 2 * BL + (VT - VSL) * HS);
    chk("frame_white", cnt_white, HA * VAL);
    chk("max_x", max_x, HA - 1);
    chk("max_y", max_y, VAL - 1);

    // Third frame: brief drop of i_en mid-frame, then a real drop that drains the frame.
    while (m_pos != 2 * FRAME + 8 * HT) step(1'b1);
    repeat (100) step(1'b0);
    repeat (HT) step(1'b1);
    while (m_run) step(1'b0);
    repeat (3) step(1'b0);
    meas_clear();
    meas_on = 1'b1;
    repeat (2000) step(1'b0);
    meas_on = 1'b0;
    chk("idle_strobes", cnt_fs, 0);
    chk("idle_sync_low", cnt_slow, 0);
    chk("idle_pix_req", cnt_req, 0);

    step(1'b1);
    chk("restart_strobe", o_frame_start, 1'b1);

    // Asynchronous reset in the middle of an active line.
    while (m_pos != 8 * HT + 400) step(1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_sync", o_sync, 1'b1);
    chk("midrst_white", o_white, 1'b0);
    chk("midrst_pix_req", o_pix_req, 1'b0);
    chk("midrst_x", o_x, 10'd0);
    chk("midrst_y", o_y, 9'd0);
    chk("midrst_frame_start", o_frame_start, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    step(1'b1);
    chk("post_rst_strobe", o_frame_start, 1'b1);
    repeat (2 * HT) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
